usb_tx_byte_serializer: RTL

USB full-speed transmit datapath. It accepts bytes over a valid/ready handshake and serializes them LSB first. It inserts a stuff bit after each run of six ones, NRZI-encodes the stream and drives D+/D-. It finishes each packet with SE0,SE0,J. It is the transmit counterpart of the RX 8-bit deserializer and shares the same bit-rate strobe (shift_enable).

---
 rtl/usb_tx_pkg.sv | 23 ++
 rtl/usb_tx_nrzi_enc.sv | 66 ++++++
 rtl/usb_tx_byte_serializer.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB full-speed transmit serializer.
package usb_tx_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        EOP_SE0 = 2'd2,
        EOP_J   = 2'd3
    } tx_state_e;

    // Line symbols encoded as {dp, dm}
    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_SE0 = 2'b00;

    localparam int DEFAULT_STUFF_LEN    = 6;
    localparam int DEFAULT_EOP_SE0_BITS = 2;

    function automatic int eop_cnt_width(input int se0_bits);
        return (se0_bits < 2) ? 1 : $clog2(se0_bits + 1);
    endfunction

endpackage

// File: rtl/usb_tx_nrzi_enc.sv
// Bit stuffer and NRZI line encoder; owns the D+/D- registers and the ones run counter.
module usb_tx_nrzi_enc
    import usb_tx_pkg::*;
#(
    parameter int STUFF_LEN = DEFAULT_STUFF_LEN
) (
    input  logic clk,
    input  logic rst,
    input  logic shift_enable,
    input  logic emit,
    input  logic data_bit,
    input  logic se0,
    input  logic force_j,
    output logic stuff_req,
    output logic dp,
    output logic dm
);

    localparam logic [2:0] STUFF_LEN_C = 3'(STUFF_LEN);

    logic       level_r;
    logic [2:0] ones_cnt_r;
    logic [1:0] line_r;
    logic       line_bit_s;
    logic       next_level_s;

    assign stuff_req = (ones_cnt_r == STUFF_LEN_C);
    assign dp        = line_r[1];
    assign dm        = line_r[0];

    // Wire bit for this strobe: a pending stuffed zero pre-empts the data bit
    always_comb begin
        if (stuff_req) begin
            line_bit_s = 1'b0;
        end else begin
            line_bit_s = data_bit;
        end
        if (line_bit_s) begin
            next_level_s = level_r;
        end else begin
            next_level_s = !level_r;
        end
    end

    // Line register, NRZI level and ones run length, all advanced on the bit strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            level_r    <= 1'b1;
            ones_cnt_r <= 3'd0;
            line_r     <= LINE_J;
        end else if (shift_enable) begin
            if (force_j) begin
                level_r    <= 1'b1;
                ones_cnt_r <= 3'd0;
                line_r     <= LINE_J;
            end else if (se0) begin
                line_r <= LINE_SE0;
            end else if (emit) begin
                level_r    <= next_level_s;
                ones_cnt_r <= line_bit_s ? (ones_cnt_r + 3'd1) : 3'd0;
                line_r     <= next_level_s ? LINE_J : LINE_K;
            end
        end
    end

endmodule

// File: rtl/usb_tx_byte_serializer.sv
// USB full-speed transmit path: byte handshake, LSB-first shifting, stuffing/NRZI and EOP.
module usb_tx_byte_serializer
    import usb_tx_pkg::*;
#(
    parameter int STUFF_LEN    = DEFAULT_STUFF_LEN,
    parameter int EOP_SE0_BITS = DEFAULT_EOP_SE0_BITS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       shift_enable,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       dp,
    output logic       dm,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error
);

    localparam int                   EOP_CNT_W    = eop_cnt_width(EOP_SE0_BITS);
    localparam logic [EOP_CNT_W-1:0] EOP_CNT_ONE  = EOP_CNT_W'(1);
    localparam logic [EOP_CNT_W-1:0] EOP_CNT_LAST = EOP_CNT_W'(EOP_SE0_BITS);

    tx_state_e            state_r;
    logic [7:0]           hold_data_r;
    logic                 hold_last_r;
    logic                 hold_full_r;
    logic                 last_acc_r;
    logic [7:0]           sh_data_r;
    logic                 sh_last_r;
    logic                 sh_valid_r;
    logic [2:0]           idx_r;
    logic                 last_sent_r;
    logic                 discard_r;
    logic [EOP_CNT_W-1:0] eop_cnt_r;
    logic [EOP_CNT_W-1:0] eop_cnt_inc_s;
    logic                 tx_busy_r;
    logic                 tx_done_r;
    logic                 tx_error_r;

    logic accept_s;
    logic xfer_s;
    logic underrun_s;
    logic eop_j_stb_s;
    logic enc_emit_s;
    logic enc_bit_s;
    logic enc_se0_s;
    logic enc_j_s;
    logic stuff_req_s;

    assign tx_ready      = !hold_full_r && !last_acc_r;
    assign accept_s      = tx_valid && tx_ready;
    assign underrun_s    = shift_enable && (state_r == SHIFT) && !stuff_req_s
                           && !sh_valid_r && !last_sent_r;
    assign xfer_s        = hold_full_r && !sh_valid_r && !discard_r && !underrun_s;
    assign eop_j_stb_s   = shift_enable && (state_r == EOP_J);
    assign eop_cnt_inc_s = eop_cnt_r + EOP_CNT_ONE;

    assign tx_busy  = tx_busy_r;
    assign tx_done  = tx_done_r;
    assign tx_error = tx_error_r;

    // Holding register; after an underrun it swallows bytes until the EOP completes
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_data_r <= 8'h00;
            hold_last_r <= 1'b0;
            hold_full_r <= 1'b0;
            last_acc_r  <= 1'b0;
        end else begin
            if (underrun_s || discard_r) begin
                hold_full_r <= 1'b0;
            end else if (accept_s) begin
                hold_full_r <= 1'b1;
                hold_data_r <= tx_data;
                hold_last_r <= tx_last;
            end else if (xfer_s) begin
                hold_full_r <= 1'b0;
            end
            if (accept_s && tx_last) begin
                last_acc_r <= 1'b1;
            end else if (eop_j_stb_s) begin
                last_acc_r <= 1'b0;
            end
        end
    end

    // Tells the line encoder what to put on the wire at the coming strobe
    always_comb begin
        enc_emit_s = 1'b0;
        enc_se0_s  = 1'b0;
        enc_j_s    = 1'b0;
        enc_bit_s  = sh_data_r[idx_r];
        case (state_r)
            IDLE: begin
                if (sh_valid_r) begin
                    enc_emit_s = 1'b1;
                end else begin
                    enc_j_s = 1'b1;
                end
            end
            SHIFT: begin
                if (stuff_req_s || sh_valid_r) begin
                    enc_emit_s = 1'b1;
                end else begin
                    enc_se0_s = 1'b1;
                end
            end
            EOP_SE0: enc_se0_s = 1'b1;
            EOP_J:   enc_j_s   = 1'b1;
            default: enc_j_s   = 1'b1;
        endcase
    end

    // Packet sequencer: shift register, bit index, EOP timing and status pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            sh_data_r   <= 8'h00;
            sh_last_r   <= 1'b0;
            sh_valid_r  <= 1'b0;
            idx_r       <= 3'd0;
            last_sent_r <= 1'b0;
            discard_r   <= 1'b0;
            eop_cnt_r   <= '0;
            tx_busy_r   <= 1'b0;
            tx_done_r   <= 1'b0;
            tx_error_r  <= 1'b0;
        end else begin
            tx_done_r  <= 1'b0;
            tx_error_r <= 1'b0;
            if (xfer_s) begin
                sh_data_r  <= hold_data_r;
                sh_last_r  <= hold_last_r;
                sh_valid_r <= 1'b1;
                idx_r      <= 3'd0;
            end
            if (shift_enable) begin
                case (state_r)
                    IDLE: begin
                        if (sh_valid_r) begin
                            idx_r       <= idx_r + 3'd1;
                            state_r     <= SHIFT;
                            tx_busy_r   <= 1'b1;
                            last_sent_r <= 1'b0;
                        end
                    end
                    SHIFT: begin
                        // A stuff strobe leaves the byte position untouched
                        if (!stuff_req_s) begin
                            if (sh_valid_r) begin
                                if (idx_r == 3'd7) begin
                                    sh_valid_r  <= 1'b0;
                                    last_sent_r <= sh_last_r;
                                end
                                idx_r <= idx_r + 3'd1;
                            end else begin
                                eop_cnt_r <= EOP_CNT_ONE;
                                state_r   <= (EOP_CNT_ONE == EOP_CNT_LAST) ? EOP_J : EOP_SE0;
                                if (!last_sent_r) begin
                                    tx_error_r <= 1'b1;
                                    discard_r  <= 1'b1;
                                end
                            end
                        end
                    end
                    EOP_SE0: begin
                        eop_cnt_r <= eop_cnt_inc_s;
                        if (eop_cnt_inc_s == EOP_CNT_LAST) begin
                            state_r <= EOP_J;
                        end
                    end
                    EOP_J: begin
                        state_r     <= IDLE;
                        tx_busy_r   <= 1'b0;
                        tx_done_r   <= 1'b1;
                        last_sent_r <= 1'b0;
                        discard_r   <= 1'b0;
                    end
                    default: state_r <= IDLE;
                endcase
            end
        end
    end

    usb_tx_nrzi_enc #(
        .STUFF_LEN(STUFF_LEN)
    ) u_nrzi (
        .clk         (clk),
        .rst         (rst),
        .shift_enable(shift_enable),
        .emit        (enc_emit_s),
        .data_bit    (enc_bit_s),
        .se0         (enc_se0_s),
        .force_j     (enc_j_s),
        .stuff_req   (stuff_req_s),
        .dp          (dp),
        .dm          (dm)
    );

endmodule
